// File: rtl/aes_byte_framer.sv
// Purpose: packs received bytes into a 128-bit AES block, starts the core, and streams the ciphertext back out as 16 bytes.
// Latency: the 16th byte is accepted in T, aes_start fires in T+1; aes_done in D gives the first tx byte in D+1.
// Backpressure: rx_ready is low from START until the drain completes; tx bytes hold steady until tx_ready accepts them.
module aes_byte_framer #(
    parameter logic [7:0]  PAD_BYTE     = 8'h00,
    parameter int unsigned WAIT_TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic         rx_ready,
    input  logic         flush,
    output logic         aes_start,
    output logic [127:0] aes_plaintext,
    input  logic         aes_done,
    input  logic [127:0] aes_ciphertext,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         tx_last,
    output logic         busy,
    output logic         err_timeout
);

    localparam logic [1:0] S_FILL  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    // Last wait count before the watchdog gives up on the core.
    localparam logic [15:0] WAIT_LAST = 16'(WAIT_TIMEOUT - 1);

    logic [1:0]   state;
    logic [3:0]   rx_cnt;
    logic [119:0] fill_buf;   // at most 15 bytes are ever held; the 16th goes straight to aes_plaintext
    logic [15:0]  wait_cnt;
    logic [3:0]   tx_cnt;
    logic [127:0] tx_shift;

    logic         rx_acc;
    logic         blk_full;
    logic         do_flush;
    logic [4:0]   n_bytes;
    logic [4:0]   n_pad;
    logic [6:0]   sh_bits;
    logic [127:0] blk_raw;
    logic [127:0] padded;

    assign rx_ready = (state == S_FILL);
    assign busy     = (state != S_FILL);
    assign tx_data  = tx_shift[127:120];

    assign rx_acc   = (state == S_FILL) && rx_valid;
    assign n_bytes  = {1'b0, rx_cnt} + {4'd0, rx_acc};
    assign blk_full = rx_acc && (rx_cnt == 4'd15);
    assign do_flush = (state == S_FILL) && flush && (n_bytes != 5'd0) && !blk_full;
    assign n_pad    = 5'd16 - n_bytes;
    assign sh_bits  = {n_pad[3:0], 3'b000};

    // Left-justify a partial block (including any byte accepted this cycle) and pad the tail.
    always_comb begin
        blk_raw = rx_acc ? {fill_buf, rx_data} : {8'h00, fill_buf};
        padded  = blk_raw << sh_bits;
        for (int i = 0; i < 16; i++) begin
            if (5'(i) < n_pad) begin
                padded[8*i +: 8] = PAD_BYTE;
            end
        end
    end

    // Block sequencer: fill, start the core, wait with watchdog, drain ciphertext.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_FILL;
            rx_cnt        <= 4'd0;
            fill_buf      <= '0;
            wait_cnt      <= 16'd0;
            tx_cnt        <= 4'd0;
            tx_shift      <= '0;
            aes_start     <= 1'b0;
            aes_plaintext <= '0;
            tx_valid      <= 1'b0;
            tx_last       <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            aes_start   <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                S_FILL: begin
                    if (rx_acc) begin
                        fill_buf <= {fill_buf[111:0], rx_data};
                        rx_cnt   <= rx_cnt + 4'd1;
                    end
                    // A flush on the 16th byte is just a full block, so blk_full wins.
                    if (blk_full || do_flush) begin
                        aes_plaintext <= blk_full ? {fill_buf, rx_data} : padded;
                        aes_start     <= 1'b1;
                        rx_cnt        <= 4'd0;
                        fill_buf      <= '0;
                        state         <= S_START;
                    end
                end
                S_START: begin
                    wait_cnt <= 16'd0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (aes_done) begin
                        tx_shift <= aes_ciphertext;
                        tx_cnt   <= 4'd0;
                        tx_valid <= 1'b1;
                        tx_last  <= 1'b0;
                        state    <= S_DRAIN;
                    end else if (wait_cnt == WAIT_LAST) begin
                        // Core never answered: drop the block and reopen for input.
                        err_timeout <= 1'b1;
                        rx_cnt      <= 4'd0;
                        fill_buf    <= '0;
                        state       <= S_FILL;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                S_DRAIN: begin
                    if (tx_ready) begin
                        tx_shift <= {tx_shift[119:0], 8'h00};
                        tx_cnt   <= tx_cnt + 4'd1;
                        tx_last  <= (tx_cnt == 4'd14);
                        if (tx_cnt == 4'd15) begin
                            tx_valid <= 1'b0;
                            tx_last  <= 1'b0;
                            rx_cnt   <= 4'd0;
                            state    <= S_FILL;
                        end
                    end
                end
                default: state <= S_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_byte_framer.sv
// Purpose: directed bench for aes_byte_framer with a behavioural AES core and a tx byte scoreboard.
// Latency: checks start, first-byte and drain-complete cycles against the aes_done cycle.
// Backpressure: exercises a 1-in-3 tx_ready pattern and rx back-pressure during a drain.
module tb_aes_byte_framer;

    localparam int          TMO      = 20;
    localparam int          CORE_LAT = 4;
    localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] XK      = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   rx_data = 8'h00;
    logic         rx_valid = 1'b0;
    logic         rx_ready;
    logic         flush = 1'b0;
    logic         aes_start;
    logic [127:0] aes_plaintext;
    logic         aes_done = 1'b0;
    logic [127:0] aes_ciphertext = '0;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready = 1'b1;
    logic         tx_last;
    logic         busy;
    logic         err_timeout;

    int checks = 0;
    int errors = 0;

    aes_byte_framer #(.PAD_BYTE(8'h00), .WAIT_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .flush(flush),
        .aes_start(aes_start), .aes_plaintext(aes_plaintext),
        .aes_done(aes_done), .aes_ciphertext(aes_ciphertext),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] ct_of(input logic [127:0] pt);
        return (pt == FIPS_PT) ? FIPS_CT : (pt ^ XK);
    endfunction

    // Scoreboard of expected tx bytes, in transmit order.
    logic [7:0] sb[$];

    task automatic push_ct(input logic [127:0] pt);
        logic [127:0] ct;
        ct = ct_of(pt);
        for (int i = 0; i < 16; i++) sb.push_back(ct[127-8*i -: 8]);
    endtask

    // Behavioural AES core: answers each start after CORE_LAT cycles when enabled.
    int   start_cnt = 0;
    int   done_cyc = 0;
    bit   core_en = 1'b1;
    int   inject_req = 0;
    int   inject_seen = 0;
    logic [127:0] core_pt;
    always begin
        @(negedge clk);
        if (rst_n && aes_start) begin
            start_cnt++;
            core_pt = aes_plaintext;
            if (core_en) begin
                repeat (CORE_LAT) @(posedge clk);
                #1;
                aes_ciphertext = ct_of(core_pt);
                aes_done = 1'b1;
                done_cyc = cyc;
                @(posedge clk); #1;
                aes_done = 1'b0;
                aes_ciphertext = '0;
            end
        end else if (inject_req != inject_seen) begin
            inject_seen = inject_req;
            @(posedge clk); #1;
            aes_ciphertext = '1;
            aes_done = 1'b1;
            @(posedge clk); #1;
            aes_done = 1'b0;
            aes_ciphertext = '0;
        end
    end

    // tx_ready source: always ready, or ready one cycle in three.
    bit bp_mode = 1'b0;
    always @(posedge clk) begin
        #1;
        tx_ready = bp_mode ? ((cyc % 3) == 0) : 1'b1;
    end

    // tx monitor: scoreboard pop on handshake, tx_last position, stability while stalled.
    int   hs_idx = 0;
    int   blocks_done = 0;
    int   first_tx_cyc = 0;
    int   last_hs_cyc = 0;
    bit   first_seen = 1'b0;
    bit   stalled = 1'b0;
    logic [7:0] stall_dat = 8'h00;
    int   err_pulses = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            hs_idx  = 0;
            stalled = 1'b0;
        end else begin
            if (err_timeout) err_pulses++;
            if (stalled) begin
                chk("stall_valid", tx_valid, 1);
                chk("stall_data", tx_data, stall_dat);
                stalled = 1'b0;
            end
            if (tx_valid && !first_seen) begin
                first_seen = 1'b1;
                first_tx_cyc = cyc;
            end
            if (tx_valid && tx_ready) begin
                chk("tx_last", tx_last, hs_idx == 15);
                checks++;
                assert (sb.size() > 0) else begin
                    errors++;
                    $error("FAIL tx_unexpected observed=%h expected=none", tx_data);
                end
                if (sb.size() > 0) chk("tx_data", tx_data, sb.pop_front());
                if (hs_idx == 15) begin
                    last_hs_cyc = cyc;
                    hs_idx = 0;
                    blocks_done++;
                end else begin
                    hs_idx++;
                end
            end else if (tx_valid) begin
                stalled = 1'b1;
                stall_dat = tx_data;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit with_flush);
        int budget;
        budget = 300;
        rx_data = b;
        rx_valid = 1'b1;
        flush = with_flush;
        while (!rx_ready && budget > 0) begin
            step();
            budget--;
        end
        checks++;
        assert (budget > 0) else begin
            errors++;
            $error("FAIL rx_accept_bound observed=%0d expected=>0", budget);
        end
        step();
        rx_valid = 1'b0;
        flush = 1'b0;
    endtask

    // Sends 16 bytes; returns in the cycle after the last acceptance.
    task automatic run_block(input logic [127:0] pt, input bit last_flush);
        for (int i = 0; i < 16; i++) send_byte(pt[127-8*i -: 8], last_flush && (i == 15));
    endtask

    task automatic wait_drain(input string tag);
        int budget;
        budget = 400;
        while (!rx_ready && budget > 0) begin
            step();
            budget--;
        end
        checks++;
        assert (budget > 0) else begin
            errors++;
            $error("FAIL %s_drain_bound observed=%0d expected=>0", tag, budget);
        end
        chk({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    initial begin
        #500000;
        errors++;
        $display("FAIL global_time_limit observed=expired expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "time limit");
    end

    initial begin
        int s0;
        int b0;
        int cs;
        int rdy_cyc;
        int budget;
        logic [127:0] pt;
        logic [127:0] pt2;

        // Reset state
        #1;
        chk("rst_rx_ready", rx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_aes_start", aes_start, 0);
        chk("rst_plaintext", aes_plaintext, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_last", tx_last, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_err", err_timeout, 0);
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("post_rst_rx_ready", rx_ready, 1);

        // Full FIPS-197 block with exact timing
        push_ct(FIPS_PT);
        first_seen = 1'b0;
        s0 = start_cnt;
        run_block(FIPS_PT, 1'b0);
        chk("A_start", aes_start, 1);
        chk("A_busy", busy, 1);
        chk("A_rx_ready", rx_ready, 0);
        chk("A_plaintext", aes_plaintext, FIPS_PT);
        step();
        chk("A_start_one_cycle", aes_start, 0);
        budget = 400;
        while (!rx_ready && budget > 0) begin step(); budget--; end
        rdy_cyc = cyc;
        chk("A_first_tx_cycle", first_tx_cyc, done_cyc + 1);
        chk("A_last_tx_cycle", last_hs_cyc, done_cyc + 16);
        chk("A_rx_ready_cycle", rdy_cyc, done_cyc + 17);
        chk("A_sb_empty", sb.size(), 0);
        chk("A_start_count", start_cnt, s0 + 1);

        // Partial flush: 41 42 43 then flush
        pt = {24'h414243, 104'h0};
        push_ct(pt);
        s0 = start_cnt;
        send_byte(8'h41, 1'b0);
        send_byte(8'h42, 1'b0);
        send_byte(8'h43, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("B_start", aes_start, 1);
        chk("B_plaintext", aes_plaintext, pt);
        step();
        chk("B_start_one_cycle", aes_start, 0);
        wait_drain("B");
        chk("B_start_count", start_cnt, s0 + 1);

        // Flush in the same cycle as the only byte
        pt = {8'h7e, 120'h0};
        push_ct(pt);
        send_byte(8'h7e, 1'b1);
        chk("B2_start", aes_start, 1);
        chk("B2_plaintext", aes_plaintext, pt);
        wait_drain("B2");

        // Flush with nothing buffered is ignored
        s0 = start_cnt;
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (4) step();
        chk("B3_no_start", start_cnt, s0);
        chk("B3_busy", busy, 0);

        // Flush coincident with byte 16
        pt = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;
        push_ct(pt);
        s0 = start_cnt;
        run_block(pt, 1'b1);
        chk("C_plaintext", aes_plaintext, pt);
        wait_drain("C");
        chk("C_start_count", start_cnt, s0 + 1);

        // Watchdog: core silent, late done ignored
        core_en = 1'b0;
        s0 = start_cnt;
        run_block(128'h0102030405060708090a0b0c0d0e0f10, 1'b0);
        cs = cyc;
        budget = 100;
        while (!err_timeout && budget > 0) begin step(); budget--; end
        chk("E_err_cycle", cyc, cs + 1 + TMO);
        step();
        chk("E_err_one_cycle", err_timeout, 0);
        chk("E_rx_ready", rx_ready, 1);
        chk("E_busy", busy, 0);
        inject_req++;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("E_late_done_tx_valid", tx_valid, 0);
        end
        chk("E_err_pulses", err_pulses, 1);
        chk("E_start_count", start_cnt, s0 + 1);
        core_en = 1'b1;

        // Back-pressure drain with rx held valid, then the next block
        bp_mode = 1'b1;
        pt  = 128'h8899aabbccddeeff0011223344556677;
        pt2 = 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf;
        push_ct(pt);
        push_ct(pt2);
        b0 = blocks_done;
        run_block(pt, 1'b0);
        chk("D_plaintext", aes_plaintext, pt);
        rx_data = pt2[127:120];
        rx_valid = 1'b1;
        budget = 600;
        while (!rx_ready && budget > 0) begin step(); budget--; end
        chk("D_drained_before_rx", blocks_done, b0 + 1);
        chk("D_sb_after_drain", sb.size(), 16);
        step();
        rx_valid = 1'b0;
        bp_mode = 1'b0;
        for (int i = 1; i < 16; i++) send_byte(pt2[127-8*i -: 8], 1'b0);
        chk("D2_plaintext", aes_plaintext, pt2);
        wait_drain("D2");

        // Reset after the 5th tx byte
        pt = 128'h00ff11ee22dd33cc44bb55aa669977aa;
        push_ct(pt);
        run_block(pt, 1'b0);
        budget = 200;
        while (hs_idx != 5 && budget > 0) begin step(); budget--; end
        chk("F_reached_5th", hs_idx, 5);
        rst_n = 1'b0;
        #1;
        chk("F_tx_valid_async", tx_valid, 0);
        chk("F_rx_ready_async", rx_ready, 1);
        chk("F_plaintext_async", aes_plaintext, 0);
        sb.delete();
        s0 = start_cnt;
        step();
        step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("F_rx_ready", rx_ready, 1);
        chk("F_no_tx", tx_valid, 0);
        chk("F_no_start", start_cnt, s0);
        push_ct(FIPS_PT);
        run_block(FIPS_PT, 1'b0);
        chk("F_plaintext", aes_plaintext, FIPS_PT);
        wait_drain("F");

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
